// File: rtl/breakout_ctrl.sv
// Game-flow controller for a breakout game: state machine, BCD score, lives,
// inter-ball / game-over timer and the registered final pixel-colour mux.
module breakout_ctrl #(
  parameter int TIMER_TICKS = 120,
  parameter int START_LIVES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_on,
  input  logic [4:0]  btn,
  input  logic        hit,
  input  logic        miss,
  input  logic        graph_on,
  input  logic [11:0] graph_rgb,
  input  logic        text_on,
  input  logic [11:0] text_rgb,
  output logic        gra_still,
  output logic [1:0]  state,
  output logic [3:0]  dig1,
  output logic [3:0]  dig0,
  output logic [1:0]  lives,
  output logic [11:0] rgb
);

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam logic [6:0] TIMER_LOAD = 7'(TIMER_TICKS);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [11:0] BG_RGB    = 12'hff0;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_timer;
  logic [6:0]  w_timer_nxt;
  logic [7:0]  r_score;
  logic [7:0]  w_score_nxt;
  logic [1:0]  r_lives;
  logic [1:0]  w_lives_nxt;
  logic [11:0] r_rgb;
  logic [11:0] w_rgb_nxt;
  logic        w_refr_tick;
  logic        w_timer_done;
  logic        w_btn_any;

  // Two-digit BCD increment; 99 rolls over to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
    logic [3:0] units;
    logic [3:0] tens;
    units = bcd[3:0];
    tens  = bcd[7:4];
    if (units == 4'd9) begin
      units = 4'd0;
      if (tens == 4'd9) begin
        tens = 4'd0;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  assign w_refr_tick  = (pix_y == 10'd481) && (pix_x == 10'd0);
  assign w_timer_done = (r_timer == 7'd0);
  assign w_btn_any    = (btn != 5'd0);

  // Next-state, timer, score and lives decode.
  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_lives_nxt = r_lives;
    if (w_refr_tick && !w_timer_done) begin
      w_timer_nxt = r_timer - 7'd1;
    end else begin
      w_timer_nxt = r_timer;
    end

    case (r_state)
      ST_NEWGAME: begin
        w_score_nxt = 8'h00;
        w_lives_nxt = LIVES_INIT;
        if (w_btn_any) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = ST_NEWGAME;
        end
      end
      ST_PLAY: begin
        if (hit) begin
          w_score_nxt = bcd_inc(r_score);
        end else begin
          w_score_nxt = r_score;
        end
        // A miss reloads the timer; the same cycle may also score a hit.
        if (miss) begin
          w_lives_nxt = r_lives - 2'd1;
          w_timer_nxt = TIMER_LOAD;
          if (r_lives == 2'd1) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_NEWBALL;
          end
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_NEWBALL: begin
        if (w_timer_done && w_btn_any) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = ST_NEWBALL;
        end
      end
      ST_OVER: begin
        if (w_timer_done) begin
          w_state_nxt = ST_NEWGAME;
          w_score_nxt = 8'h00;
          w_lives_nxt = LIVES_INIT;
        end else begin
          w_state_nxt = ST_OVER;
        end
      end
      default: begin
        w_state_nxt = ST_NEWGAME;
      end
    endcase
  end

  // Game-flow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_NEWGAME;
      r_timer <= 7'd0;
      r_score <= 8'h00;
      r_lives <= LIVES_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_score <= w_score_nxt;
      r_lives <= w_lives_nxt;
    end
  end

  // Pixel colour priority: blanking, text overlay, graphics, background.
  always_comb begin
    if (!video_on) begin
      w_rgb_nxt = 12'h000;
    end else if (text_on) begin
      w_rgb_nxt = text_rgb;
    end else if (graph_on) begin
      w_rgb_nxt = graph_rgb;
    end else begin
      w_rgb_nxt = BG_RGB;
    end
  end

  // Registered colour output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb <= 12'h000;
    end else begin
      r_rgb <= w_rgb_nxt;
    end
  end

  assign state     = r_state;
  assign gra_still = (r_state != ST_PLAY);
  assign dig1      = r_score[7:4];
  assign dig0      = r_score[3:0];
  assign lives     = r_lives;
  assign rgb       = r_rgb;

endmodule

// File: tb/tb_breakout_ctrl.sv
// Randomized scoreboard bench for breakout_ctrl against an integer game model.
module tb_breakout_ctrl;

  localparam int TT = 120;
  localparam int SL = 3;

  logic        clk;
  logic        reset;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        video_on;
  logic [4:0]  btn;
  logic        hit;
  logic        miss;
  logic        graph_on;
  logic [11:0] graph_rgb;
  logic        text_on;
  logic [11:0] text_rgb;
  logic        gra_still;
  logic [1:0]  state;
  logic [3:0]  dig1;
  logic [3:0]  dig0;
  logic [1:0]  lives;
  logic [11:0] rgb;

  breakout_ctrl #(.TIMER_TICKS(TT), .START_LIVES(SL)) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .video_on(video_on), .btn(btn), .hit(hit), .miss(miss),
    .graph_on(graph_on), .graph_rgb(graph_rgb),
    .text_on(text_on), .text_rgb(text_rgb),
    .gra_still(gra_still), .state(state), .dig1(dig1), .dig0(dig0),
    .lives(lives), .rgb(rgb)
  );

  typedef struct {
    int st;
    int gs;
    int d1;
    int d0;
    int lv;
    int rgb;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Game model: plain integers, score kept as 0..99.
  int m_state = 0;
  int m_timer = 0;
  int m_score = 0;
  int m_lives = SL;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare DUT outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(state), e.st);
        chk("gra_still", int'(gra_still), e.gs);
        chk("dig1", int'(dig1), e.d1);
        chk("dig0", int'(dig0), e.d0);
        chk("lives", int'(lives), e.lv);
        chk("rgb", int'(rgb), e.rgb);
      end
    end
  end

  task automatic model_step();
    exp_t e;
    bit   refr;
    bit   loaded;
    int   old_t;
    if (reset) begin
      m_state = 0; m_timer = 0; m_score = 0; m_lives = SL;
      e.rgb = 0;
    end else begin
      if (!video_on)     e.rgb = 0;
      else if (text_on)  e.rgb = int'(text_rgb);
      else if (graph_on) e.rgb = int'(graph_rgb);
      else               e.rgb = 'hff0;
      refr   = (pix_y == 10'd481) && (pix_x == 10'd0);
      loaded = 0;
      old_t  = m_timer;
      case (m_state)
        0: if (btn != 5'd0) m_state = 1;
        1: begin
          if (hit) m_score = (m_score + 1) % 100;
          if (miss) begin
            m_lives = m_lives - 1;
            m_state = (m_lives == 0) ? 3 : 2;
            m_timer = TT;
            loaded  = 1;
          end
        end
        2: if (old_t == 0 && btn != 5'd0) m_state = 1;
        3: if (old_t == 0) begin
          m_state = 0; m_score = 0; m_lives = SL;
        end
        default: m_state = 0;
      endcase
      if (!loaded && refr && old_t > 0) m_timer = old_t - 1;
    end
    e.st = m_state;
    e.gs = (m_state != 1) ? 1 : 0;
    e.d1 = m_score / 10;
    e.d0 = m_score % 10;
    e.lv = m_lives;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [4:0] b, input logic h, input logic m,
                     input logic rf, input logic rs);
    @(negedge clk);
    reset = rs; btn = b; hit = h; miss = m;
    if (rf) begin
      pix_x = 10'd0; pix_y = 10'd481;
    end else begin
      pix_x = 10'($urandom_range(0, 799));
      pix_y = 10'($urandom_range(0, 480));
    end
    video_on  = ($urandom_range(0, 3) != 0);
    text_on   = 1'($urandom_range(0, 1));
    graph_on  = 1'($urandom_range(0, 1));
    text_rgb  = 12'($urandom);
    graph_rgb = 12'($urandom);
    model_step();
  endtask

  initial begin
    reset = 1'b1; btn = 5'd0; hit = 1'b0; miss = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0; video_on = 1'b0;
    text_on = 1'b0; graph_on = 1'b0; text_rgb = 12'h000; graph_rgb = 12'h000;

    cyc(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(5'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    // Ten hits, then up to 99 and one more to wrap.
    for (int i = 0; i < 10; i++) begin
      cyc(5'd0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      cyc(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 90; i++) cyc(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Lose a ball with the button held through the whole timer.
    cyc(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cyc(5'h04, 1'b1, 1'b1, 1'(i % 2), 1'b0);
    cyc(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 125; i++) cyc(5'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    // Last ball: hit and miss together.
    cyc(5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 125; i++) cyc(5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    // Reset in NEWBALL with the timer at 50.
    cyc(5'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200 && m_timer > 50; i++) cyc(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("model_timer_50", m_timer, 50);
    cyc(5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(5'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    cyc(5'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    // Random play.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
          1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 799) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
